video_pattern_gen: RTL and testbench



---
 rtl/video_pattern_gen_if.sv | 11 +
 rtl/video_pattern_gen.sv | 105 ++++++++++
 tb/tb_video_pattern_gen.sv | 136 +++++++++++++
 3 files changed

// File: rtl/video_pattern_gen_if.sv
// video_pattern_gen_if: RGB565 raster stream plus frame status from the pattern generator
interface video_pattern_gen_if;
  logic        pg_hs;
  logic        pg_vs;
  logic        pg_de;
  logic [15:0] pg_data;
  logic [15:0] pg_frame_cnt;
  logic        pg_frame_done;
  modport master (output pg_hs, pg_vs, pg_de, pg_data, pg_frame_cnt, pg_frame_done);
  modport slave  (input  pg_hs, pg_vs, pg_de, pg_data, pg_frame_cnt, pg_frame_done);
endinterface

// File: rtl/video_pattern_gen.sv
// video_pattern_gen: raster-timed RGB565 test pattern source with frame-boundary config shadowing
module video_pattern_gen #(
  parameter int H_DISP = 1280,
  parameter int H_FP   = 110,
  parameter int H_SYNC = 40,
  parameter int H_BP   = 220,
  parameter int V_DISP = 720,
  parameter int V_FP   = 5,
  parameter int V_SYNC = 5,
  parameter int V_BP   = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [31:0]                PG_CR,
  input  logic [15:0]                PG_COLOR,
  output logic                       pg_clk,
  video_pattern_gen_if.master        vo
);
  localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_DISP / 8;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [10:0] bar_px;
  logic [2:0]  bar_idx;
  logic [1:0]  sh_mode;
  logic        sh_scroll;
  logic [15:0] sh_color;
  logic        h_end, v_end, frame_end, bar_end, active, hs, vs;
  logic [7:0]  s, p;
  logic [10:0] cx;
  logic [15:0] pix;
  logic        unused_cr;
  assign pg_clk    = clk;
  assign unused_cr = ^PG_CR[31:4];
  always_comb begin
    h_end     = h_cnt == 11'(H_TOTAL - 1);
    v_end     = v_cnt == 10'(V_TOTAL - 1);
    frame_end = h_end && v_end;
    bar_end   = bar_px == 11'(BAR_W - 1);
    active    = h_cnt < 11'(H_DISP) && v_cnt < 10'(V_DISP);
    hs        = h_cnt >= 11'(H_DISP + H_FP) && h_cnt < 11'(H_DISP + H_FP + H_SYNC);
    vs        = v_cnt >= 10'(V_DISP + V_FP) && v_cnt < 10'(V_DISP + V_FP + V_SYNC);
    s         = sh_scroll ? vo.pg_frame_cnt[7:0] : 8'd0;
    p         = h_cnt[7:0] + s;
    cx        = h_cnt + {3'd0, s};
    pix       = sh_mode == 2'd0 ? sh_color :
                sh_mode == 2'd1 ? BARS[bar_idx] :
                sh_mode == 2'd2 ? {p[7:3], p[7:2], p[7:3]} :
                (cx[5] ^ v_cnt[5]) ? sh_color : 16'h0000;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      h_cnt            <= '0;
      v_cnt            <= '0;
      bar_px           <= '0;
      bar_idx          <= '0;
      sh_mode          <= '0;
      sh_scroll        <= 1'b0;
      sh_color         <= '0;
      vo.pg_hs         <= 1'b0;
      vo.pg_vs         <= 1'b0;
      vo.pg_de         <= 1'b0;
      vo.pg_data       <= '0;
      vo.pg_frame_cnt  <= '0;
      vo.pg_frame_done <= 1'b0;
    end else if (state == IDLE) begin
      vo.pg_hs         <= 1'b0;
      vo.pg_vs         <= 1'b0;
      vo.pg_de         <= 1'b0;
      vo.pg_data       <= '0;
      vo.pg_frame_done <= 1'b0;
      if (PG_CR[0]) begin
        state     <= RUN;
        sh_mode   <= PG_CR[2:1];
        sh_scroll <= PG_CR[3];
        sh_color  <= PG_COLOR;
      end
    end else begin
      vo.pg_hs         <= hs;
      vo.pg_vs         <= vs;
      vo.pg_de         <= active;
      vo.pg_data       <= active ? pix : 16'h0000;
      vo.pg_frame_done <= frame_end;
      h_cnt            <= h_end ? 11'd0 : h_cnt + 11'd1;
      bar_px           <= (h_end || bar_end) ? 11'd0 : bar_px + 11'd1;
      bar_idx          <= h_end ? 3'd0 : bar_idx + 3'(bar_end);
      if (h_end)
        v_cnt <= v_end ? 10'd0 : v_cnt + 10'd1;
      if (frame_end) begin
        vo.pg_frame_cnt <= vo.pg_frame_cnt + 16'd1;
        sh_mode         <= PG_CR[2:1];
        sh_scroll       <= PG_CR[3];
        sh_color        <= PG_COLOR;
        if (!PG_CR[0])
          state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen: directed checks of raster timing, patterns, shadowing, EN drop and reset on a reduced raster
module tb_video_pattern_gen;
  localparam int HD = 264, HF = 4, HS = 4, HB = 8;
  localparam int VD = 34, VF = 1, VS = 2, VB = 1;
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam int FT = HT * VT;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] cr = 32'h0;
  logic [15:0] color = 16'h0;
  logic        pg_clk;
  int          n_chk = 0, n_fail = 0, cyc = 0;
  video_pattern_gen_if vo();
  video_pattern_gen #(.H_DISP(HD), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                      .V_DISP(VD), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) dut (
    .clk(clk), .rst_n(rst_n), .PG_CR(cr), .PG_COLOR(color), .pg_clk(pg_clk), .vo(vo));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    cyc++;
  endtask
  function automatic int px(input int f, input int l, input int p);
    return 2 + f * FT + l * HT + p;
  endfunction
  task automatic go(input int k);
    while (cyc < k) step();
  endtask
  initial begin
    int de_n = 0, bad = 0, hs_n = 0, hs_rise = 0, vs_n = 0, done_n = 0, overlap = 0, idle_act = 0;
    logic hs_q = 1'b0;
    cr = 32'h1;
    color = 16'h1234;
    repeat (3) @(negedge clk);
    check("rst_de", vo.pg_de, 0);
    check("rst_data", vo.pg_data, 0);
    check("pg_clk", pg_clk, clk);
    rst_n = 1'b1;
    cyc = 0;
    step();
    check("start_de", vo.pg_de, 0);
    check("start_fc", vo.pg_frame_cnt, 0);
    for (int k = 0; k < FT; k++) begin
      step();
      de_n    += int'(vo.pg_de);
      bad     += int'(vo.pg_de ? vo.pg_data != 16'h1234 : vo.pg_data != 16'h0);
      hs_n    += int'(vo.pg_hs);
      hs_rise += int'(vo.pg_hs && !hs_q);
      vs_n    += int'(vo.pg_vs);
      done_n  += int'(vo.pg_frame_done);
      overlap += int'(vo.pg_vs && vo.pg_de);
      hs_q     = vo.pg_hs;
      if (cyc == px(0, 10, 0)) color = 16'h07E0;
    end
    check("f0_de_cycles", de_n, HD * VD);
    check("f0_bad_pixels", bad, 0);
    check("f0_hs_cycles", hs_n, HS * VT);
    check("f0_hs_pulses", hs_rise, VT);
    check("f0_vs_cycles", vs_n, VS * HT);
    check("f0_done_pulses", done_n, 1);
    check("f0_vs_de_overlap", overlap, 0);
    check("f0_fc", vo.pg_frame_cnt, 1);
    step();
    check("f1_shadow_color", vo.pg_data, 16'h07E0);
    check("f1_de", vo.pg_de, 1);
    cr = 32'hD;
    go(px(2, 0, 0)); check("ramp_s2_p0", vo.pg_data, 16'h0000);
    go(px(2, 0, 2)); check("ramp_s2_p2", vo.pg_data, 16'h0020);
    go(px(2, 0, 6)); check("ramp_s2_p6", vo.pg_data, 16'h0841);
    go(px(2, 0, 253)); check("ramp_s2_p253", vo.pg_data, 16'hFFFF);
    go(px(2, 0, 254)); check("ramp_s2_p254", vo.pg_data, 16'h0000);
    go(px(3, 0, 0)); check("ramp_s3_p0", vo.pg_data, 16'h0000);
    go(px(3, 0, 5)); check("ramp_s3_p5", vo.pg_data, 16'h0841);
    go(px(3, 0, 252)); check("ramp_s3_p252", vo.pg_data, 16'hFFFF);
    cr = 32'h7;
    color = 16'hFFFF;
    go(px(4, 0, 0)); check("chk_l0_p0", vo.pg_data, 16'h0000);
    go(px(4, 0, 31)); check("chk_l0_p31", vo.pg_data, 16'h0000);
    go(px(4, 0, 32)); check("chk_l0_p32", vo.pg_data, 16'hFFFF);
    go(px(4, 0, 63)); check("chk_l0_p63", vo.pg_data, 16'hFFFF);
    go(px(4, 0, 64)); check("chk_l0_p64", vo.pg_data, 16'h0000);
    go(px(4, 31, 0)); check("chk_l31_p0", vo.pg_data, 16'h0000);
    go(px(4, 32, 0)); check("chk_l32_p0", vo.pg_data, 16'hFFFF);
    go(px(4, 32, 32)); check("chk_l32_p32", vo.pg_data, 16'h0000);
    go(px(4, 33, 0)); check("chk_l33_p0", vo.pg_data, 16'hFFFF);
    cr = 32'h6;
    go(px(5, 0, 0) - 1);
    check("endis_done", vo.pg_frame_done, 1);
    check("endis_fc", vo.pg_frame_cnt, 5);
    repeat (300) begin
      step();
      idle_act += int'(vo.pg_de || vo.pg_hs || vo.pg_vs || vo.pg_frame_done || vo.pg_data != 16'h0);
    end
    check("idle_quiet", idle_act, 0);
    check("idle_fc_hold", vo.pg_frame_cnt, 5);
    cr = 32'h3;
    cyc = 0;
    go(px(0, 20, 50));
    check("bars_mid_p50", vo.pg_data, 16'hFFE0);
    check("pre_rst_fc", vo.pg_frame_cnt, 5);
    rst_n = 1'b0;
    step();
    check("rst_mid_de", vo.pg_de, 0);
    check("rst_mid_data", vo.pg_data, 0);
    check("rst_mid_hsvs", {vo.pg_hs, vo.pg_vs, vo.pg_frame_done}, 0);
    check("rst_mid_fc", vo.pg_frame_cnt, 0);
    repeat (2) step();
    rst_n = 1'b1;
    cyc = 0;
    step(); check("rs_first_de", vo.pg_de, 0);
    step(); check("rs_p0_de", vo.pg_de, 1);
    check("rs_p0_data", vo.pg_data, 16'hFFFF);
    go(px(0, 0, 32)); check("bars_p32", vo.pg_data, 16'hFFFF);
    go(px(0, 0, 33)); check("bars_p33", vo.pg_data, 16'hFFE0);
    go(px(0, 0, 66)); check("bars_p66", vo.pg_data, 16'h07FF);
    go(px(0, 0, 263)); check("bars_p263", vo.pg_data, 16'h0000);
    check("bars_p263_de", vo.pg_de, 1);
    go(px(0, 0, 264)); check("de_fall", vo.pg_de, 0);
    go(px(0, 0, 267)); check("hs_pre", vo.pg_hs, 0);
    go(px(0, 0, 268)); check("hs_rise", vo.pg_hs, 1);
    go(px(0, 0, 271)); check("hs_last", vo.pg_hs, 1);
    go(px(0, 0, 272)); check("hs_fall", vo.pg_hs, 0);
    go(px(0, 34, 279)); check("vs_pre", vo.pg_vs, 0);
    go(px(0, 35, 0)); check("vs_rise", vo.pg_vs, 1);
    check("vs_no_de", vo.pg_de, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
